// File: rtl/button_press_if.sv
// Button level in, gesture event pulses and busy flag out, between the debouncer side and the decoder.
interface button_press_if;
    logic btn;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output btn,
        input  short_pulse,
        input  double_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  busy
    );

    modport slave (
        input  btn,
        output short_pulse,
        output double_pulse,
        output long_pulse,
        output repeat_pulse,
        output busy
    );
endinterface

// File: rtl/button_press_decoder.sv
// Classifies debounced button gestures into short, double, long and auto-repeat events,
// each reported as a registered single-cycle pulse.
module button_press_decoder #(
    parameter int unsigned CNT_W        = 27,
    parameter int unsigned LONG_COUNT   = 100_000_000,
    parameter int unsigned REPEAT_COUNT = 25_000_000,
    parameter int unsigned DOUBLE_GAP   = 30_000_000
) (
    input  logic          clk,
    input  logic          rst,
    button_press_if.slave bp
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             btn_d;
    logic             rise;
    logic             fall;

    logic short_q,  short_next;
    logic double_q, double_next;
    logic long_q,   long_next;
    logic repeat_q, repeat_next;
    logic busy_q,   busy_next;

    assign rise = bp.btn & ~btn_d;
    assign fall = ~bp.btn & btn_d;

    // btn_d resets high so a button held through reset is not taken as a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_d    <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            btn_d    <= bp.btn;
            short_q  <= short_next;
            double_q <= double_next;
            long_q   <= long_next;
            repeat_q <= repeat_next;
            busy_q   <= busy_next;
        end
    end

    // Gesture classification; the shared counter restarts on every state change
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESS1;
                    cnt_next   = '0;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_next = WAIT2;
                    cnt_next   = '0;
                end else if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            WAIT2: begin
                // A rise on the expiry cycle still counts as the second press
                if (rise) begin
                    double_next = 1'b1;
                    state_next  = PRESS2;
                    cnt_next    = '0;
                end else if (cnt == GAP_LAST) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            LONG: begin
                if (fall) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    repeat_next = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bp.short_pulse  = short_q;
    assign bp.double_pulse = double_q;
    assign bp.long_pulse   = long_q;
    assign bp.repeat_pulse = repeat_q;
    assign bp.busy         = busy_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: directed segment table, reset sequences and random
// button activity checked cycle by cycle against a timestamp-based gesture model.
module tb_button_press_decoder;

    localparam int unsigned CNT_W        = 4;
    localparam int unsigned LONG_COUNT   = 8;
    localparam int unsigned REPEAT_COUNT = 4;
    localparam int unsigned DOUBLE_GAP   = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_press_if bp ();

    button_press_decoder #(
        .CNT_W        (CNT_W),
        .LONG_COUNT   (LONG_COUNT),
        .REPEAT_COUNT (REPEAT_COUNT),
        .DOUBLE_GAP   (DOUBLE_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: gestures tracked as timestamps of the events that started them
    int   k;
    logic m_prev;
    int   t_press;
    int   t_rel;
    int   t_long;
    logic second;
    logic [4:0] exp_vec;

    int c_short, c_double, c_long, c_repeat;

    typedef struct {
        logic btn;
        int   n;
        int   e_short;
        int   e_double;
        int   e_long;
        int   e_repeat;
        logic e_busy;
    } seg_t;

    seg_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task model_reset();
        m_prev  = 1'b1;
        t_press = -1;
        t_rel   = -1;
        t_long  = -1;
        second  = 1'b0;
    endtask

    task model_edge(input logic b);
        logic e_s, e_d, e_l, e_r, r;
        e_s = 0; e_d = 0; e_l = 0; e_r = 0;
        if (rst) begin
            model_reset();
        end else begin
            r = b && !m_prev;
            if (t_press >= 0) begin
                if (!b) begin
                    t_press = -1;
                    t_rel   = k;
                end else if (k - t_press == int'(LONG_COUNT)) begin
                    e_l     = 1;
                    t_press = -1;
                    t_long  = k;
                end
            end else if (t_rel >= 0) begin
                if (r) begin
                    e_d    = 1;
                    t_rel  = -1;
                    second = 1'b1;
                end else if (k - t_rel == int'(DOUBLE_GAP)) begin
                    e_s   = 1;
                    t_rel = -1;
                end
            end else if (second) begin
                if (!b) second = 1'b0;
            end else if (t_long >= 0) begin
                if (!b) t_long = -1;
                else if ((k - t_long) % int'(REPEAT_COUNT) == 0) e_r = 1;
            end else if (r) begin
                t_press = k;
            end
            m_prev = b;
        end
        exp_vec = {e_s, e_d, e_l, e_r,
                   (!rst) && ((t_press >= 0) || (t_rel >= 0) || second || (t_long >= 0))};
        k++;
    endtask

    // Drive one btn sample (from a negedge), let the clock edge take it, then compare
    task step(input logic b);
        logic [4:0] obs;
        bp.btn = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        obs = {bp.short_pulse, bp.double_pulse, bp.long_pulse, bp.repeat_pulse, bp.busy};
        check("cycle_vs_model", int'(obs), int'(exp_vec));
        c_short  += int'(bp.short_pulse);
        c_double += int'(bp.double_pulse);
        c_long   += int'(bp.long_pulse);
        c_repeat += int'(bp.repeat_pulse);
    endtask

    task clear_counts();
        c_short = 0; c_double = 0; c_long = 0; c_repeat = 0;
    endtask

    function automatic seg_t mk(logic b, int n, int s, int d, int l, int r, logic busy);
        seg_t x;
        x.btn = b; x.n = n; x.e_short = s; x.e_double = d;
        x.e_long = l; x.e_repeat = r; x.e_busy = busy;
        return x;
    endfunction

    initial begin
        logic lvl;
        int   len;

        tbl.push_back(mk(0, 3,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 1));   // short press
        tbl.push_back(mk(0, 6,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 1));   // double press
        tbl.push_back(mk(0, 2,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 2,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 22, 0, 0, 1, 3, 1));   // long press with repeats
        tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8,  0, 0, 0, 0, 1));   // one sample short of long
        tbl.push_back(mk(0, 6,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9,  0, 0, 1, 0, 1));   // exactly long
        tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 1));   // second rise on last gap cycle
        tbl.push_back(mk(0, 5,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 1));   // second rise one cycle too late
        tbl.push_back(mk(0, 6,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 6,  1, 0, 0, 0, 0));

        k = 0;
        model_reset();
        bp.btn = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'({bp.short_pulse, bp.double_pulse, bp.long_pulse,
                                     bp.repeat_pulse, bp.busy}), 0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            clear_counts();
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].btn);
            check($sformatf("seg%0d_short", i),  c_short,  tbl[i].e_short);
            check($sformatf("seg%0d_double", i), c_double, tbl[i].e_double);
            check($sformatf("seg%0d_long", i),   c_long,   tbl[i].e_long);
            check($sformatf("seg%0d_repeat", i), c_repeat, tbl[i].e_repeat);
            check($sformatf("seg%0d_busy", i),   int'(bp.busy), int'(tbl[i].e_busy));
        end

        // Reset during LONG with the button held, released while still held
        clear_counts();
        for (int j = 0; j < 10; j++) step(1'b1);
        check("pre_rst_long", c_long, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", int'({bp.short_pulse, bp.double_pulse, bp.long_pulse,
                                         bp.repeat_pulse, bp.busy}), 0);
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        clear_counts();
        for (int j = 0; j < 12; j++) step(1'b1);
        check("post_rst_events", c_short + c_double + c_long + c_repeat, 0);
        check("post_rst_busy", int'(bp.busy), 0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("post_rst_new_press", int'(bp.busy), 1);
        clear_counts();
        for (int j = 0; j < 6; j++) step(1'b0);
        check("post_rst_short", c_short, 1);

        // Random run lengths with occasional resets
        lvl = 1'b0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                len = int'($urandom_range(1, 3));
                for (int j = 0; j < len; j++) step(1'($urandom_range(0, 1)));
                rst = 1'b0;
            end else begin
                lvl = ~lvl;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                                  : int'($urandom_range(1, 10));
                for (int j = 0; j < len; j++) step(lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_press_decoder.md
Name: button_press_decoder

Overview:
- Sits directly downstream of the button debouncer in the rgb_display path.
- Consumes the clean, debounced button level and classifies each gesture as one of: short press, double press, long press, or held auto-repeat.
- Emits one single-cycle event pulse per classification for the colour/mode controller to consume.
- Removes press-timing logic from the display control FSM.

Parameters:
- CNT_W, 27, width of the shared timing counter; every count parameter must be < 2^CNT_W.
- LONG_COUNT, 100_000_000, hold cycles that qualify a long press (1 s at 100 MHz); must be >= 2.
- REPEAT_COUNT, 25_000_000, cycles between auto-repeat pulses while held after a long press (250 ms); must be >= 2.
- DOUBLE_GAP, 30_000_000, max released cycles after the first press that still allow a double press (300 ms); must be >= 2.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-high reset.
- btn, input, 1, debounced button level, synchronous to clk.
- short_pulse, output, 1, one-cycle pulse: short press confirmed.
- double_pulse, output, 1, one-cycle pulse: second press detected inside the gap window.
- long_pulse, output, 1, one-cycle pulse: hold reached LONG_COUNT.
- repeat_pulse, output, 1, one-cycle pulse: each REPEAT_COUNT interval held after long_pulse.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Edge detect:
  - btn_d <= btn every cycle.
  - rise = btn & ~btn_d.
  - fall = ~btn & btn_d.
- Reset (async, rst=1):
  - state=IDLE, cnt=0.
  - All pulse outputs 0; busy 0.
  - btn_d resets to 1, so a button held through reset release is not a press. A press is recognised only after btn is seen low.
- All outputs are registered. Pulses are high for exactly one cycle and mutually exclusive.
- IDLE:
  - On rise: go to PRESS1, cnt<=0.
- PRESS1:
  - btn=1 and cnt<LONG_COUNT-1: cnt<=cnt+1.
  - btn=1 and cnt==LONG_COUNT-1: long_pulse<=1, go to LONG, cnt<=0. long_pulse therefore rises LONG_COUNT cycles after entry to PRESS1.
  - btn=0 (fall) before that: go to WAIT2, cnt<=0.
- WAIT2:
  - rise: double_pulse<=1, go to PRESS2.
  - No rise and cnt==DOUBLE_GAP-1: short_pulse<=1, go to IDLE. short_pulse rises DOUBLE_GAP cycles after entry to WAIT2.
  - Otherwise: cnt<=cnt+1.
  - Simultaneous rise and gap expiry: rise wins, giving double_pulse and no short_pulse.
- PRESS2:
  - Wait for fall, then go to IDLE.
  - No long/repeat detection for the second press, however long it is held.
- LONG:
  - btn=1 and cnt==REPEAT_COUNT-1: repeat_pulse<=1, cnt<=0.
  - btn=1 otherwise: cnt<=cnt+1.
  - fall: go to IDLE.
  - No short_pulse is ever generated after a long press.
- Counter:
  - Unsigned CNT_W bits.
  - Never wraps: it is compared against limits and reset before overflow.
- Reset mid-operation: immediate return to IDLE; any pulse in flight is dropped.
- busy is combinationally (state != IDLE) and registered by nature of the state register.

Test Plan (LONG_COUNT=8, REPEAT_COUNT=4, DOUBLE_GAP=5, CNT_W=4):
1. Short press:
   - Stimulus: btn high 3 cycles, then low.
   - Required: short_pulse high for exactly 1 cycle, 5 cycles after the fall is sampled. No other pulse. busy drops the cycle after.
2. Double press:
   - Stimulus: btn high 3, low 2, high 3, low.
   - Required: double_pulse 1 cycle, the cycle after the second rise. No short_pulse. busy low after the second fall.
3. Long press with repeat:
   - Stimulus: btn high 20 cycles.
   - Required: long_pulse at hold cycle 8; repeat_pulse at hold cycles 12, 16 and 20. On release: IDLE with no short_pulse.
4. Long-press boundary:
   - Stimulus: hold 7 cycles.
   - Required: classified short (short_pulse after the gap).
   - Stimulus: hold 8 cycles.
   - Required: long_pulse and no short_pulse.
5. Gap boundary:
   - Stimulus: second rise exactly on the cycle cnt==4 in WAIT2.
   - Required: double_pulse only.
   - Stimulus: second rise one cycle later.
   - Required: short_pulse, followed by a fresh PRESS1 sequence.
6. Reset cases:
   - Stimulus: assert rst during LONG while btn is high; release rst with btn still high.
   - Required: all outputs 0 immediately. No event until btn goes low and rises again.
